// File: rtl/pc_gen.sv
// pc_gen: RV32 fetch PC generator with prioritised redirects; optional return-address stack under PC_RAS_EN
module pc_gen #(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pc_ready,
  input  logic            trap_flag,
  input  logic [XLEN-1:0] trap_addr,
  input  logic            jump_flag,
  input  logic [XLEN-1:0] jump_addr,
  input  logic            ras_push,
  input  logic [XLEN-1:0] ras_push_addr,
  input  logic            ras_pop,
  output logic [XLEN-1:0] pc_out,
  output logic            pc_valid,
  output logic            misalign_err,
  output logic            ras_empty
);
  logic            ras_hit;
  logic [XLEN-1:0] ras_top;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] pc_next;
`ifdef PC_RAS_EN
  localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CW = $clog2(RAS_DEPTH + 1);
  logic [XLEN-1:0] ras_mem [RAS_DEPTH];
  logic [PW-1:0]   ptr;
  logic [CW-1:0]   count;
  logic            push;
  assign push      = ras_push & ~trap_flag & ~jump_flag;
  assign ras_hit   = ras_pop & ~trap_flag & ~jump_flag & (count != '0);
  assign ras_top   = ras_mem[ptr];
  assign ras_empty = count == '0;
  // ptr names the top entry; a push+pop pair rewrites the top in place, a full push overwrites the oldest slot
  always_ff @(posedge clk)
    if (rst) begin
      ptr   <= '0;
      count <= '0;
    end else if (push && ras_hit) begin
      ras_mem[ptr] <= ras_push_addr;
    end else if (push) begin
      ras_mem[ptr + 1'b1] <= ras_push_addr;
      ptr                 <= ptr + 1'b1;
      count               <= (count == CW'(RAS_DEPTH)) ? count : count + 1'b1;
    end else if (ras_hit) begin
      ptr   <= ptr - 1'b1;
      count <= count - 1'b1;
    end
`else
  localparam int unused_depth = RAS_DEPTH;
  logic unused_ras;
  assign unused_ras = ^{ras_push, ras_pop, ras_push_addr};
  assign ras_hit    = 1'b0;
  assign ras_top    = '0;
  assign ras_empty  = 1'b1;
`endif
  assign target  = trap_flag ? trap_addr : jump_flag ? jump_addr : ras_top;
  assign pc_next = (trap_flag | jump_flag | ras_hit) ? (target & ~XLEN'(3))
                 : (pc_valid & pc_ready) ? pc_out + XLEN'(4) : pc_out;
  // PC register, sticky valid and one-cycle misaligned-target pulse
  always_ff @(posedge clk)
    if (rst) begin
      pc_out       <= RESET_VECTOR;
      pc_valid     <= 1'b0;
      misalign_err <= 1'b0;
    end else begin
      pc_out       <= pc_next;
      pc_valid     <= 1'b1;
      misalign_err <= trap_flag ? |trap_addr[1:0] : jump_flag & |jump_addr[1:0];
    end
endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: randomized scoreboard bench for pc_gen against a queue-based reference model
module tb_pc_gen;
  localparam logic [31:0] RV = 32'h0000_1000;
  localparam int DEPTH = 4;
`ifdef PC_RAS_EN
  localparam bit RAS_EN = 1'b1;
`else
  localparam bit RAS_EN = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst, pc_ready, trap_flag, jump_flag, ras_push, ras_pop;
  logic [31:0] trap_addr, jump_addr, ras_push_addr, pc_out;
  logic pc_valid, misalign_err, ras_empty;
  typedef struct {
    logic [31:0] pc;
    logic v, m, e;
  } exp_t;
  exp_t exp_q[$];
  exp_t x;
  int compared = 0, mismatched = 0, cyc = 0;
  logic [31:0] m_pc;
  bit m_v, m_m;
  logic [31:0] m_ras[$];

  pc_gen #(.XLEN(32), .RESET_VECTOR(RV), .RAS_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .pc_ready(pc_ready),
    .trap_flag(trap_flag), .trap_addr(trap_addr),
    .jump_flag(jump_flag), .jump_addr(jump_addr),
    .ras_push(ras_push), .ras_push_addr(ras_push_addr), .ras_pop(ras_pop),
    .pc_out(pc_out), .pc_valid(pc_valid), .misalign_err(misalign_err), .ras_empty(ras_empty)
  );

  always #5 clk = ~clk;

  task automatic model_step(input bit r, rdy, tf, input logic [31:0] ta, input bit jf,
                            input logic [31:0] ja, input bit pu, input logic [31:0] pa, input bit po);
    bit can_pop;
    if (r) begin
      m_pc = RV;
      m_v = 1'b0;
      m_m = 1'b0;
      m_ras.delete();
    end else begin
      can_pop = RAS_EN && po && !tf && !jf && m_ras.size() > 0;
      m_m = tf ? (ta[1:0] != 2'b00) : (jf && ja[1:0] != 2'b00);
      if (tf) m_pc = ta & ~32'h3;
      else if (jf) m_pc = ja & ~32'h3;
      else if (can_pop) m_pc = m_ras[m_ras.size()-1] & ~32'h3;
      else if (m_v && rdy) m_pc = m_pc + 32'd4;
      if (RAS_EN && !tf && !jf) begin
        if (pu && can_pop) m_ras[m_ras.size()-1] = pa;
        else if (pu) begin
          m_ras.push_back(pa);
          if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
        end else if (can_pop) void'(m_ras.pop_back());
      end
      m_v = 1'b1;
    end
  endtask

  task automatic drive(input bit r, rdy, tf, input logic [31:0] ta, input bit jf,
                       input logic [31:0] ja, input bit pu, input logic [31:0] pa, input bit po);
    exp_t e;
    rst = r; pc_ready = rdy; trap_flag = tf; trap_addr = ta; jump_flag = jf; jump_addr = ja;
    ras_push = pu; ras_push_addr = pa; ras_pop = po;
    model_step(r, rdy, tf, ta, jf, ja, pu, pa, po);
    e.pc = m_pc;
    e.v = m_v;
    e.m = m_m;
    e.e = RAS_EN ? (m_ras.size() == 0) : 1'b1;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input bit rdy);
    drive(0, rdy, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic push(input logic [31:0] a);
    drive(0, 1, 0, 0, 0, 0, 1, a, 0);
  endtask

  task automatic pop();
    drive(0, 1, 0, 0, 0, 0, 0, 0, 1);
  endtask

  always @(negedge clk) begin
    cyc++;
    if (exp_q.size() > 0) begin
      x = exp_q.pop_front();
      compared += 4;
      if (pc_out !== x.pc) begin
        mismatched++;
        $display("FAIL pc_out cyc %0d got %h expected %h", cyc, pc_out, x.pc);
      end
      if (pc_valid !== x.v) begin
        mismatched++;
        $display("FAIL pc_valid cyc %0d got %b expected %b", cyc, pc_valid, x.v);
      end
      if (misalign_err !== x.m) begin
        mismatched++;
        $display("FAIL misalign_err cyc %0d got %b expected %b", cyc, misalign_err, x.m);
      end
      if (ras_empty !== x.e) begin
        mismatched++;
        $display("FAIL ras_empty cyc %0d got %b expected %b", cyc, ras_empty, x.e);
      end
    end
  end

  initial begin
    drive(1, 1, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 1, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) idle(1);
    repeat (3) idle(0);
    idle(1);
    push(32'h0000_0060);
    drive(0, 1, 1, 32'h0000_0100, 1, 32'h0000_2000, 0, 0, 1);
    drive(0, 0, 0, 0, 1, 32'h0000_2003, 0, 0, 0);
    idle(0);
    idle(0);
    pop();
    foreach (m_ras[i]) pop();
    push(32'h0000_00A0);
    push(32'h0000_00B0);
    push(32'h0000_00C0);
    push(32'h0000_00D0);
    push(32'h0000_00E0);
    repeat (5) pop();
    idle(1);
    push(32'h0000_0040);
    drive(0, 1, 0, 0, 0, 0, 1, 32'h0000_0080, 1);
    pop();
    idle(1);
    drive(0, 1, 1, 32'h0000_0102, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 1, 32'hFFFF_FFFF, 0, 0, 0);
    repeat (2) idle(1);
    push(32'h0000_0300);
    drive(1, 1, 1, 32'h0000_0500, 1, 32'h0000_0600, 1, 32'h700, 1);
    repeat (2) idle(1);
    for (int i = 0; i < 400; i++) begin
      bit r, tf, jf;
      r = ($urandom_range(0, 63) == 0);
      tf = ($urandom_range(0, 9) == 0);
      jf = ($urandom_range(0, 7) == 0);
      drive(r, 1'($urandom), tf, $urandom, jf, $urandom, 1'($urandom), $urandom, 1'($urandom));
    end
    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL drain got %0d pending expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
